// File: rtl/cheese_spawner_if.sv
// pos_if: x/y screen position bundle shared by Jerry and the two cheeses.
//   x, y : 11-bit pixel coordinates
//   in   : consumer view (reads x/y)
//   out  : producer view (drives x/y)
interface pos_if;
   logic [10:0] x;
   logic [10:0] y;
   modport in  (input  x, y);
   modport out (output x, y);
endinterface

// File: rtl/cheese_spawner.sv
// cheese_spawner: hides taken cheeses and relocates them after a respawn delay.
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   reset           synchronous active-high game restart (same values as rst)
//   is_cheese_taken pickup pulse, bit0 = cheese 1, bit1 = cheese 2
//   jerrypos        Jerry position (pos_if.in)
//   cheesepos1/2    cheese positions (pos_if.out)
//   cheese_visible  per-cheese draw/collide enable
//   spawn_busy      high whenever the relocation FSM is not idle
// Build option: CHEESE_FIXED_SEQ_EN replaces the LFSR with a fixed 8-entry
// candidate table walked by a 3-bit counter.
module cheese_spawner #(
   parameter int          X_MIN         = 32,
   parameter int          X_MAX         = 980,
   parameter int          Y_MIN         = 100,
   parameter int          Y_MAX         = 700,
   parameter int          MIN_DIST      = 100,
   parameter int          RESPAWN_TICKS = 65_000_000,
   parameter int          MAX_TRIES     = 8,
   parameter int          INIT1_X       = 200,
   parameter int          INIT1_Y       = 600,
   parameter int          INIT2_X       = 800,
   parameter int          INIT2_Y       = 600,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       reset,
   input  logic [1:0] is_cheese_taken,
   pos_if.in          jerrypos,
   pos_if.out         cheesepos1,
   pos_if.out         cheesepos2,
   output logic [1:0] cheese_visible,
   output logic       spawn_busy
);
   localparam int W  = 11;
   localparam int WW = $clog2(RESPAWN_TICKS + 1);
   localparam int TW = $clog2(MAX_TRIES + 1);

   typedef enum logic [2:0] {IDLE, WAIT, PICK, CHECK, PLACE} state_t;

   state_t          state, state_nx;
   logic [1:0]      pending;
   logic [1:0]      cap;
   logic [1:0]      req;
   logic [1:0]      done;
   logic            slot;
   logic [WW-1:0]   wait_ctr;
   logic [TW-1:0]   try_ctr;
   logic [W-1:0]    cand_x, cand_y;
   logic [W-1:0]    p1_x, p1_y, p2_x, p2_y;
   logic [W-1:0]    other_x, other_y;
   logic [W-1:0]    init_x, init_y;
   logic [9:0]      draw_x, draw_y;
   logic            in_range, far_jerry, far_other, valid, last_try;

   // Separation test: far enough on at least one axis, using signed
   // differences one bit wider than the position.
   function automatic logic far(input logic [W-1:0] ax, ay, bx, by);
      logic signed [W:0] dx, dy, ax_abs, ay_abs;
      dx     = $signed({1'b0, ax}) - $signed({1'b0, bx});
      dy     = $signed({1'b0, ay}) - $signed({1'b0, by});
      ax_abs = dx[W] ? -dx : dx;
      ay_abs = dy[W] ? -dy : dy;
      return (ax_abs >= $signed((W+1)'(MIN_DIST))) || (ay_abs >= $signed((W+1)'(MIN_DIST)));
   endfunction

`ifdef CHEESE_FIXED_SEQ_EN
   localparam logic [9:0] TAB_X [8] = '{10'd100, 10'd500, 10'd900, 10'd300,
                                        10'd700, 10'd150, 10'd850, 10'd450};
   localparam logic [9:0] TAB_Y [8] = '{10'd200, 10'd650, 10'd300, 10'd500,
                                        10'd150, 10'd400, 10'd600, 10'd250};
   logic [2:0] seq_idx;

   always_ff @(posedge clk or posedge rst)
      if (rst)
         seq_idx <= '0;
      else if (reset)
         seq_idx <= '0;
      else if (state == PICK)
         seq_idx <= seq_idx + 3'd1;

   assign draw_x = TAB_X[seq_idx];
   assign draw_y = TAB_Y[seq_idx];
`else
   logic [15:0] lfsr;

   // Right-shifting Galois LFSR; a nonzero seed keeps it out of the all-zero lock-up state.
   always_ff @(posedge clk or posedge rst)
      if (rst)
         lfsr <= LFSR_SEED;
      else if (reset)
         lfsr <= LFSR_SEED;
      else
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   assign draw_x = lfsr[9:0];
   assign draw_y = lfsr[15:6];
`endif

   // A pulse only counts for a cheese that is currently visible; the FSM
   // sees same-cycle captures so a pickup goes straight from IDLE to WAIT.
   always_comb begin
      cap       = is_cheese_taken & cheese_visible;
      req       = pending | cap;
      done      = (state == PLACE) ? (slot ? 2'b10 : 2'b01) : 2'b00;
      other_x   = slot ? p1_x : p2_x;
      other_y   = slot ? p1_y : p2_y;
      init_x    = slot ? W'(INIT2_X) : W'(INIT1_X);
      init_y    = slot ? W'(INIT2_Y) : W'(INIT1_Y);
      in_range  = (int'(cand_x) >= X_MIN) && (int'(cand_x) <= X_MAX) &&
                  (int'(cand_y) >= Y_MIN) && (int'(cand_y) <= Y_MAX);
      far_jerry = far(cand_x, cand_y, jerrypos.x, jerrypos.y);
      far_other = far(cand_x, cand_y, other_x, other_y);
      valid     = in_range && far_jerry && far_other;
      last_try  = (try_ctr == TW'(MAX_TRIES - 1));
   end

   always_ff @(posedge clk or posedge rst)
      if (rst)
         state <= IDLE;
      else if (reset)
         state <= IDLE;
      else
         state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = |req ? WAIT : IDLE;
         WAIT:    state_nx = (wait_ctr == WW'(RESPAWN_TICKS - 1)) ? PICK : WAIT;
         PICK:    state_nx = CHECK;
         CHECK:   state_nx = (valid || last_try) ? PLACE : PICK;
         PLACE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb spawn_busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pending        <= '0;
         cheese_visible <= 2'b11;
         slot           <= 1'b0;
         wait_ctr       <= '0;
         try_ctr        <= '0;
         cand_x         <= '0;
         cand_y         <= '0;
         p1_x           <= W'(INIT1_X);
         p1_y           <= W'(INIT1_Y);
         p2_x           <= W'(INIT2_X);
         p2_y           <= W'(INIT2_Y);
      end else if (reset) begin
         pending        <= '0;
         cheese_visible <= 2'b11;
         slot           <= 1'b0;
         wait_ctr       <= '0;
         try_ctr        <= '0;
         cand_x         <= '0;
         cand_y         <= '0;
         p1_x           <= W'(INIT1_X);
         p1_y           <= W'(INIT1_Y);
         p2_x           <= W'(INIT2_X);
         p2_y           <= W'(INIT2_Y);
      end else begin
         pending        <= (pending | cap) & ~done;
         cheese_visible <= (cheese_visible & ~cap) | done;
         case (state)
            IDLE:
               if (|req) begin
                  slot     <= ~req[0];
                  wait_ctr <= '0;
               end
            WAIT:
               wait_ctr <= wait_ctr + 1'b1;
            PICK: begin
               cand_x <= W'(draw_x);
               cand_y <= W'(draw_y);
            end
            CHECK:
               if (!valid && last_try) begin
                  cand_x <= init_x;
                  cand_y <= init_y;
               end else if (!valid)
                  try_ctr <= try_ctr + 1'b1;
            PLACE: begin
               try_ctr <= '0;
               if (slot) begin
                  p2_x <= cand_x;
                  p2_y <= cand_y;
               end else begin
                  p1_x <= cand_x;
                  p1_y <= cand_y;
               end
            end
            default: ;
         endcase
      end

   assign cheesepos1.x = p1_x;
   assign cheesepos1.y = p1_y;
   assign cheesepos2.x = p2_x;
   assign cheesepos2.y = p2_y;
endmodule
